// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter family:
// FSM state encoding, requester count, select width and default burst length.
package arb_pkg;

   localparam int N_REQ         = 4;
   localparam int SEL_W         = 2;
   localparam int BURST_DEFAULT = 4;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// Handshake bundle between the arbiter, its four sources and the downstream consumer.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_mux_sel_arbiter_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             out_ready;
   logic [SEL_W-1:0] sel;
   logic             out_valid;
   logic [N_REQ-1:0] gnt;
   logic             busy;
`ifdef ARB_LOCK_EN
   logic             lock;
`endif

   // Arbiter side.
   modport master (
      input  req,
      input  out_ready,
`ifdef ARB_LOCK_EN
      input  lock,
`endif
      output sel,
      output out_valid,
      output gnt,
      output busy
   );

   // Sources and consumer side.
   modport slave (
      output req,
      output out_ready,
`ifdef ARB_LOCK_EN
      output lock,
`endif
      input  sel,
      input  out_valid,
      input  gnt,
      input  busy
   );

endinterface

// File: rtl/rr_mux_sel_arbiter_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping 3 -> 0.
// Reusable by any arbiter that keeps its own 'last' pointer.
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Scan from farthest to nearest so the requester closest after 'last' wins.
   always_comb begin
      pick = last;
      any  = 1'b0;
      idx  = last;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = last + SEL_W'(i);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the 4:1 data mux, with bounded bursts.
// Optional ARB_LOCK_EN adds a lock input that suspends the burst limit.
module rr_mux_sel_arbiter
   import arb_pkg::*;
#(
   parameter int BURST = BURST_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   rr_mux_sel_arbiter_if.master  bus
);

   arb_state_e       state;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] last;
   logic [CNT_W-1:0] beat_cnt;
   logic             busy;

   logic [SEL_W-1:0] pick;
   logic             any;
   logic             out_valid;
   logic             accept;
   logic             last_beat;
   logic             lock_hold;

   rr_pick u_pick (
      .req  (bus.req),
      .last (last),
      .pick (pick),
      .any  (any)
   );

`ifdef ARB_LOCK_EN
   assign lock_hold = bus.lock;
`else
   assign lock_hold = 1'b0;
`endif

   // Valid and grant are decoded from state so an async reset drops them at once.
   assign out_valid = (state == GRANT) && bus.req[sel];
   assign accept    = out_valid && bus.out_ready;
   assign last_beat = (beat_cnt == CNT_W'(BURST - 1));

   assign bus.sel       = sel;
   assign bus.out_valid = out_valid;
   assign bus.gnt       = accept ? (N_REQ'(1) << sel) : '0;
   assign bus.busy      = busy;

   // sel only moves on IDLE->GRANT, keeping the mux select stable for the whole grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         last     <= SEL_W'(N_REQ - 1);
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  state    <= GRANT;
                  sel      <= pick;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (!bus.req[sel]) begin
                  state <= IDLE;
                  last  <= sel;
                  busy  <= 1'b0;
               end else if (accept) begin
                  if (last_beat && !lock_hold) begin
                     state <= IDLE;
                     last  <= sel;
                     busy  <= 1'b0;
                  end else if (!last_beat) begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Directed self-checking bench for rr_mux_sel_arbiter (BURST=4); the lock scenario
// runs only when ARB_LOCK_EN is defined.
module tb_rr_mux_sel_arbiter;
   import arb_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   rr_mux_sel_arbiter_if bus();

   rr_mux_sel_arbiter #(.BURST(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic lk);
      bus.req       = r;
      bus.out_ready = rdy;
`ifdef ARB_LOCK_EN
      bus.lock      = lk;
`else
      if (lk) $display("[TB] note: lock ignored in this build");
`endif
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] e_sel, input logic e_valid,
                              input logic [3:0] e_gnt, input logic e_busy);
      checks++;
      assert (bus.sel === e_sel) else begin
         errors++;
         $error("[TB] FAIL %s.sel observed=%0d expected=%0d", tag, bus.sel, e_sel);
      end
      checks++;
      assert (bus.out_valid === e_valid) else begin
         errors++;
         $error("[TB] FAIL %s.out_valid observed=%b expected=%b", tag, bus.out_valid, e_valid);
      end
      checks++;
      assert (bus.gnt === e_gnt) else begin
         errors++;
         $error("[TB] FAIL %s.gnt observed=%b expected=%b", tag, bus.gnt, e_gnt);
      end
      checks++;
      assert (bus.busy === e_busy) else begin
         errors++;
         $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, bus.busy, e_busy);
      end
   endtask

   initial begin
      logic [1:0] order [5];
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("reset", 2'd0, 1'b0, 4'b0000, 1'b0);

      // Single requester: 4 beats, one bubble, re-grant.
      $display("[TB] test 1: single requester");
      doReset();
      applyStimulus(4'b0001, 1'b1, 1'b0);
      checkOutput("t1_idle", 2'd0, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t1_beat%0d", k), 2'd0, 1'b1, 4'b0001, 1'b1);
         nextCycle();
      end
      checkOutput("t1_bubble", 2'd0, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkOutput("t1_regrant", 2'd0, 1'b1, 4'b0001, 1'b1);

      // All requesting: order 0,1,2,3,0 with 4 beats each and one bubble between.
      $display("[TB] test 2: full rotation");
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
      doReset();
      applyStimulus(4'b1111, 1'b1, 1'b0);
      nextCycle();
      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t2_g%0d_beat%0d", g, k), order[g], 1'b1,
                        4'b0001 << order[g], 1'b1);
            nextCycle();
         end
         checkOutput($sformatf("t2_g%0d_bubble", g), order[g], 1'b0, 4'b0000, 1'b0);
         nextCycle();
      end

      // Stall on requester 2 for 10 cycles, then 4 beats, then hand over to 3.
      $display("[TB] test 3: stall");
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      nextCycle();
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("t3_stall%0d", k), 2'd2, 1'b1, 4'b0000, 1'b1);
         nextCycle();
      end
      applyStimulus(4'b1100, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t3_beat%0d", k), 2'd2, 1'b1, 4'b0100, 1'b1);
         nextCycle();
      end
      checkOutput("t3_bubble", 2'd2, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkOutput("t3_next", 2'd3, 1'b1, 4'b1000, 1'b1);

      // Requester 1 withdraws after 2 beats; requester 3 follows.
      $display("[TB] test 4: withdraw");
      doReset();
      applyStimulus(4'b1010, 1'b1, 1'b0);
      nextCycle();
      checkOutput("t4_beat0", 2'd1, 1'b1, 4'b0010, 1'b1);
      nextCycle();
      checkOutput("t4_beat1", 2'd1, 1'b1, 4'b0010, 1'b1);
      nextCycle();
      applyStimulus(4'b1000, 1'b1, 1'b0);
      checkOutput("t4_drop", 2'd1, 1'b0, 4'b0000, 1'b1);
      nextCycle();
      checkOutput("t4_idle", 2'd1, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkOutput("t4_next", 2'd3, 1'b1, 4'b1000, 1'b1);

      // Async reset mid-burst on requester 3, then requester 0 wins.
      $display("[TB] test 5: reset mid-burst");
      doReset();
      applyStimulus(4'b1000, 1'b1, 1'b0);
      nextCycle();
      checkOutput("t5_beat0", 2'd3, 1'b1, 4'b1000, 1'b1);
      nextCycle();
      checkOutput("t5_beat1", 2'd3, 1'b1, 4'b1000, 1'b1);
      nextCycle();
      checkOutput("t5_beat2", 2'd3, 1'b1, 4'b1000, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_inreset", 2'd0, 1'b0, 4'b0000, 1'b0);
      rst_n = 1'b1;
      applyStimulus(4'b1001, 1'b1, 1'b0);
      checkOutput("t5_released", 2'd0, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkOutput("t5_first", 2'd0, 1'b1, 4'b0001, 1'b1);

`ifdef ARB_LOCK_EN
      // Lock holds requester 0 past the burst limit; unlock releases on next accept.
      $display("[TB] test 6: lock");
      doReset();
      applyStimulus(4'b0011, 1'b1, 1'b1);
      nextCycle();
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("t6_beat%0d", k), 2'd0, 1'b1, 4'b0001, 1'b1);
         nextCycle();
      end
      applyStimulus(4'b0011, 1'b1, 1'b0);
      checkOutput("t6_unlock", 2'd0, 1'b1, 4'b0001, 1'b1);
      nextCycle();
      checkOutput("t6_bubble", 2'd0, 1'b0, 4'b0000, 1'b0);
      nextCycle();
      checkOutput("t6_next", 2'd1, 1'b1, 4'b0010, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
